// File: rtl/disaggregator.sv
// Splits each wide word from a show-ahead sender into narrow words, one per cycle.
// Optional receiver_last output is enabled by defining DISAGGREGATOR_LAST_FLAG_EN.
module disaggregator #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FETCH_WIDTH = 2,
  localparam int unsigned IW = $clog2(FETCH_WIDTH) + 1
) (
  input  logic                              wclk,
  input  logic                              wrst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  input  logic                              change_fetch_width,
  input  logic [IW-1:0]                     input_fetch_width
`ifdef DISAGGREGATOR_LAST_FLAG_EN
  ,
  output logic                              receiver_last
`endif
);

  typedef enum logic [0:0] {StEmpty, StShift} state_e;

  state_e                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] buf_q, buf_d;
  logic [IW-1:0]                   active_width_q, active_width_d;
  logic [IW-1:0]                   word_width_q, word_width_d;

  logic [IW-1:0] req_width;
  logic          last_lane;
  logic          load;
  logic          enq_raw;
  logic          deq_raw;

  // Zero or oversize requests fall back to the full fetch width.
  always_comb begin
    req_width = input_fetch_width;
    if (input_fetch_width == '0 || 32'(input_fetch_width) > FETCH_WIDTH) begin
      req_width = IW'(FETCH_WIDTH);
    end
  end

  always_comb begin
    active_width_d = change_fetch_width ? req_width : active_width_q;
  end

  assign last_lane = (idx_q == word_width_q - IW'(1));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    word_width_d  = word_width_q;
    load          = 1'b0;
    enq_raw       = 1'b0;
    deq_raw       = 1'b0;
    receiver_data = '0;

    unique case (state_q)
      StEmpty: begin
        if (sender_empty_n) begin
          deq_raw = 1'b1;
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        receiver_data = buf_q[DATA_WIDTH*32'(idx_q) +: DATA_WIDTH];
        enq_raw       = receiver_full_n;
        if (receiver_full_n) begin
          if (!last_lane) begin
            idx_d = idx_q + IW'(1);
          end else if (sender_empty_n) begin
            // Reload in the same cycle as the final lane so the stream has no bubble.
            deq_raw = 1'b1;
            load    = 1'b1;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase

    if (load) begin
      buf_d        = sender_data;
      idx_d        = '0;
      word_width_d = active_width_d;
    end
  end

  assign sender_deq   = deq_raw & wrst_n;
  assign receiver_enq = enq_raw & wrst_n;

`ifdef DISAGGREGATOR_LAST_FLAG_EN
  assign receiver_last = receiver_enq & last_lane;
`endif

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q        <= StEmpty;
      idx_q          <= '0;
      buf_q          <= '0;
      active_width_q <= IW'(FETCH_WIDTH);
      word_width_q   <= IW'(FETCH_WIDTH);
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      buf_q          <= buf_d;
      active_width_q <= active_width_d;
      word_width_q   <= word_width_d;
    end
  end

endmodule

// File: tb/tb_disaggregator.sv
// Scoreboard bench: each sent wide word queues its expected narrow words; a monitor checks them.
module tb_disaggregator;
  localparam int DW = 8;
  localparam int FW = 2;
  localparam int IW = $clog2(FW) + 1;

  logic               wclk = 1'b0;
  logic               wrst_n;
  logic [FW*DW-1:0]   sender_data;
  logic               sender_empty_n;
  logic               sender_deq;
  logic [DW-1:0]      receiver_data;
  logic               receiver_full_n;
  logic               receiver_enq;
  logic               change_fetch_width;
  logic [IW-1:0]      input_fetch_width;
`ifdef DISAGGREGATOR_LAST_FLAG_EN
  logic               receiver_last;
`endif

  disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .wclk               (wclk),
    .wrst_n             (wrst_n),
    .sender_data        (sender_data),
    .sender_empty_n     (sender_empty_n),
    .sender_deq         (sender_deq),
    .receiver_data      (receiver_data),
    .receiver_full_n    (receiver_full_n),
    .receiver_enq       (receiver_enq),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width)
`ifdef DISAGGREGATOR_LAST_FLAG_EN
    ,
    .receiver_last      (receiver_last)
`endif
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t             exp_q[$];
  logic [FW*DW-1:0] sq[$];
  int checks = 0;
  int failures = 0;
  int enq_cnt = 0;
  int deq_cnt = 0;
  bit pop_pending = 0;
  bit gap = 0;
  bit rand_full = 0;
  int model_w = FW;

  function automatic int clamp(int v);
    return (v == 0 || v > FW) ? FW : v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples a few time units after the falling edge, well clear of the rising edge.
  always @(negedge wclk) begin
    exp_t e;
    #3;
    if (!wrst_n) begin
      check("rst_enq", 32'(receiver_enq), 0);
      check("rst_deq", 32'(sender_deq), 0);
      pop_pending = 0;
    end else begin
      check("deq_when_empty", 32'(sender_deq & ~sender_empty_n), 0);
      if (receiver_enq) begin
        enq_cnt++;
        check("enq_while_full", 32'(receiver_full_n), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(receiver_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("data", 32'(receiver_data), 32'(e.data));
`ifdef DISAGGREGATOR_LAST_FLAG_EN
          check("last", 32'(receiver_last), 32'(e.last));
`endif
        end
      end else begin
`ifdef DISAGGREGATOR_LAST_FLAG_EN
        check("last_idle", 32'(receiver_last), 0);
`endif
      end
      if (sender_deq) deq_cnt++;
      pop_pending = sender_deq;
    end
  end

  task automatic refresh();
    sender_empty_n = (sq.size() != 0) && !gap;
    sender_data    = (sq.size() != 0) ? sq[0] : '0;
  endtask

  task automatic tick();
    @(negedge wclk);
    if (pop_pending) begin
      if (sq.size() != 0) void'(sq.pop_front());
      pop_pending = 0;
    end
    if (rand_full) receiver_full_n = ($urandom_range(0, 3) != 0);
    gap = rand_full && ($urandom_range(0, 4) == 0);
    refresh();
  endtask

  task automatic send(logic [FW*DW-1:0] w);
    exp_t e;
    sq.push_back(w);
    for (int i = 0; i < model_w; i++) begin
      e.data = w[i*DW +: DW];
      e.last = (i == model_w - 1);
      exp_q.push_back(e);
    end
    refresh();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || sq.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < 400), 1);
    rand_full = 0;
    gap = 0;
    receiver_full_n = 1;
    tick();
    tick();
  endtask

  task automatic set_width(int v);
    int n = 0;
    while (sq.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check("set_width_timeout", 32'(n < 400), 1);
    change_fetch_width = 1;
    input_fetch_width  = IW'(v);
    model_w = clamp(v);
    tick();
    change_fetch_width = 0;
  endtask

  initial begin
    int e0;
    int d0;
    wrst_n = 0;
    sender_empty_n = 0;
    sender_data = '0;
    receiver_full_n = 1;
    change_fetch_width = 0;
    input_fetch_width = '0;
    repeat (3) tick();
    wrst_n = 1;
    tick();
    #1;
    check("idle_enq", 32'(receiver_enq), 0);
    check("idle_data", 32'(receiver_data), 0);
    check("idle_deq", 32'(sender_deq), 0);

    // Back-to-back words: four consecutive narrow words, two pops.
    e0 = enq_cnt;
    d0 = deq_cnt;
    send(16'h0100);
    send(16'h0302);
    repeat (5) tick();
    check("b2b_enq_count", 32'(enq_cnt - e0), 4);
    check("b2b_deq_count", 32'(deq_cnt - d0), 2);
    drain();

    // Receiver stall on lane 1.
    send(16'h0504);
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      receiver_full_n = 0;
      #1;
      check("stall_data", 32'(receiver_data), 32'h05);
      check("stall_enq", 32'(receiver_enq), 0);
    end
    tick();
    receiver_full_n = 1;
    send(16'h0706);
    drain();

    // Width change in the same cycle as the load applies to that word.
    e0 = enq_cnt;
    d0 = deq_cnt;
    change_fetch_width = 1;
    input_fetch_width = IW'(1);
    model_w = 1;
    send(16'h0A0B);
    tick();
    change_fetch_width = 0;
    send(16'h0C0D);
    drain();
    check("w1_enq_count", 32'(enq_cnt - e0), 2);
    check("w1_deq_count", 32'(deq_cnt - d0), 2);

    // Out-of-range widths fall back to full width.
    set_width(0);
    send(16'h1312);
    drain();
    set_width(1);
    set_width(3);
    send(16'h1514);
    drain();

    // Reset restores full width.
    set_width(1);
    drain();
    wrst_n = 0;
    model_w = FW;
    tick();
    wrst_n = 1;
    send(16'h1716);
    drain();

    // Reset mid-word drops the remaining lane.
    send(16'h2211);
    tick();
    tick();
    wrst_n = 0;
    exp_q.delete();
    sq.delete();
    pop_pending = 0;
    model_w = FW;
    refresh();
    tick();
    wrst_n = 1;
    send(16'h4433);
    drain();

    // Randomized phases with stalls, sender gaps and width changes between bursts.
    for (int p = 0; p < 8; p++) begin
      rand_full = 1;
      set_width($urandom_range(0, 3));
      for (int n = 0; n < 30; n++) begin
        tick();
        if (sq.size() < 3 && $urandom_range(0, 1) == 1) send(16'($urandom));
      end
      drain();
    end

    check("final_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/disaggregator.md
DISAGGREGATOR -- requirements
Module: disaggregator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one narrow word.
REQ-002 SHALL have parameter FETCH_WIDTH, default 2, maximum number of narrow words per wide word.
REQ-003 SHALL have port wclk  input  1  write-side clock; all state updates on rising edge.
REQ-004 SHALL have port wrst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sender_data  input  FETCH_WIDTH*DATA_WIDTH  wide word, show-ahead, valid while sender_empty_n=1; lane 0 = bits [DATA_WIDTH-1:0].
REQ-006 SHALL have port sender_empty_n  input  1  sender holds a wide word.
REQ-007 SHALL have port sender_deq  output  1  pops sender this cycle.
REQ-008 SHALL have port receiver_data  output  DATA_WIDTH  current narrow word.
REQ-009 SHALL have port receiver_full_n  input  1  receiver can accept a word.
REQ-010 SHALL have port receiver_enq  output  1  receiver_data transferred this cycle.
REQ-011 SHALL have port change_fetch_width  input  1  load input_fetch_width.
REQ-012 SHALL have port input_fetch_width  input  $clog2(FETCH_WIDTH)+1  requested words per wide word.

Function
REQ-013 SHALL implement two states: EMPTY (no word buffered) and SHIFT (word buffered, lane index idx valid).
REQ-014 SHALL, in EMPTY with sender_empty_n=1, assert sender_deq combinationally, capture sender_data into buffer, set idx=0, go to SHIFT.
REQ-015 SHALL, in SHIFT, drive receiver_data = buffer lane idx and receiver_enq = receiver_full_n (combinational).
REQ-016 SHALL drive receiver_data = 0 and receiver_enq = 0 in EMPTY.
REQ-017 SHALL, on enq with idx < word_width-1, increment idx and hold buffer.
REQ-018 SHALL, on enq with idx = word_width-1 and sender_empty_n=1, assert sender_deq same cycle, reload buffer, set idx=0, stay SHIFT (zero-bubble, one narrow word per cycle sustained).
REQ-019 SHALL, on enq with idx = word_width-1 and sender_empty_n=0, go to EMPTY.
REQ-020 SHALL hold buffer, idx and receiver_data unchanged while receiver_full_n=0; no word lost or duplicated.
REQ-021 SHALL never assert sender_deq when sender_empty_n=0.
REQ-022 SHALL keep register active_width (reset FETCH_WIDTH), updated when change_fetch_width=1 to input_fetch_width, clamped to FETCH_WIDTH if value is 0 or > FETCH_WIDTH.
REQ-023 SHALL latch word_width per wide word at load time from active_width; if change_fetch_width=1 in the load cycle, the new clamped value applies to that word.
REQ-024 SHALL finish the in-flight word with its latched word_width when width changes mid-word.
REQ-025 SHALL discard lanes >= word_width without emitting them.

Reset
REQ-026 SHALL, on wclk edge with wrst_n=0: state=EMPTY, idx=0, buffer=0, active_width=FETCH_WIDTH, word_width=FETCH_WIDTH.
REQ-027 SHALL force sender_deq=0 and receiver_enq=0 combinationally while wrst_n=0.
REQ-028 SHALL drop any in-flight word on reset; first word after reset starts at lane 0.

Configuration
REQ-029 SHALL support macro DISAGGREGATOR_LAST_FLAG_EN.
REQ-030 SHALL, with DISAGGREGATOR_LAST_FLAG_EN defined, add output receiver_last (1 bit), high when receiver_enq=1 and idx = word_width-1, else 0; 0 in reset.
REQ-031 SHALL, without the macro, omit receiver_last port entirely; all other behaviour identical.

Verification (DATA_WIDTH=8, FETCH_WIDTH=2)
REQ-032 Sender presents 0x0100, 0x0302 back-to-back, receiver_full_n=1 -> receiver gets 0x00,0x01,0x02,0x03 on four consecutive cycles; sender_deq on cycles 1 and 3 only.
REQ-033 receiver_full_n=0 for 3 cycles while idx=1 on word 0x0504 -> receiver_data held at 0x05, no enq; after release 0x05 enqueued once, then next word.
REQ-034 change_fetch_width=1 with input 1, then words 0x0A0B, 0x0C0D -> receiver gets 0x0B, 0x0D only; sender_deq every enq cycle.
REQ-035 input_fetch_width=0 and =3 (each with change pulse) -> active_width=2; both bytes emitted.
REQ-036 wrst_n=0 one cycle after lane 0 of 0x2211 emitted -> 0x22 never emitted; next word 0x4433 yields 0x33, 0x44.
REQ-037 With DISAGGREGATOR_LAST_FLAG_EN, stream 0x0100 -> receiver_last 0 with 0x00, 1 with 0x01; with width 1, receiver_last=1 every enq.
